key_effect_sequencer: RTL and testbench

//  Turns the 8-bit keyboard key code driven by the key_code PIO into effect on/off commands.

---
 rtl/key_effect_sequencer_if.sv | 24 ++
 rtl/key_effect_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_key_effect_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/key_effect_sequencer_if.sv
// Avalon-MM write-only bus between the key sequencer (master) and the
// effect configuration register bank (slave).
interface key_effect_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] m_address;
    logic              m_write;
    logic [31:0]       m_writedata;
    logic              m_waitrequest;

    modport master (
        output m_address,
        output m_write,
        output m_writedata,
        input  m_waitrequest
    );

    modport slave (
        input  m_address,
        input  m_write,
        input  m_writedata,
        output m_waitrequest
    );
endinterface

// File: rtl/key_effect_sequencer.sv
// Turns keyboard key codes into queued effect toggle / clear-all commands and
// writes the resulting enable bits into the effect register bank over Avalon-MM.
module key_effect_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int NUM_EFFECTS = 8,
    parameter int ADDR_W      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             key_code_i,
    input  logic                   enable_i,
    key_effect_sequencer_if.master avm,
    output logic [NUM_EFFECTS-1:0] effect_state_o,
    output logic                   busy_o,
    output logic                   overflow_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0]       LAST_IDX   = 3'(NUM_EFFECTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR
    } state_t;

    typedef struct packed {
        logic       clr;
        logic [2:0] idx;
    } cmd_t;

    state_t                 state_q, state_d;
    logic [7:0]             key_q;
    cmd_t                   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]       rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [NUM_EFFECTS-1:0] effect_q, effect_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   data_q, data_d;
    logic                   write_q, write_d;
    logic [2:0]             idx_q, idx_d;
    logic                   busy_q, busy_d;
    logic                   overflow_q, overflow_d;

    logic [7:0] keyOffset;
    logic       keyEvent;
    logic       cmdValid;
    logic       pushOk;
    logic       pop;
    cmd_t       newCmd;
    cmd_t       popCmd;

    // Keys below 0x1E wrap to large offsets, so one compare covers the whole toggle range.
    always_comb begin
        keyOffset  = key_code_i - 8'h1E;
        keyEvent   = (key_code_i != key_q) && (key_code_i != 8'h00);
        newCmd.clr = (key_code_i == 8'h27);
        newCmd.idx = keyOffset[2:0];
        cmdValid   = keyEvent && enable_i &&
                     (newCmd.clr || (keyOffset < 8'(NUM_EFFECTS)));
        pushOk     = cmdValid && (count_q != FULL_COUNT);
        pop        = (state_q == IDLE) && (count_q != '0);
        popCmd     = mem_q[rdPtr_q];
    end

    always_comb begin
        state_d    = state_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        effect_d   = effect_q;
        addr_d     = addr_q;
        data_d     = data_q;
        write_d    = write_q;
        idx_d      = idx_q;
        overflow_d = overflow_q || (cmdValid && !pushOk);

        if (pushOk) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (pushOk && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!pushOk && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    write_d = 1'b1;
                    if (popCmd.clr) begin
                        effect_d = '0;
                        idx_d    = 3'd0;
                        addr_d   = '0;
                        data_d   = 1'b0;
                        state_d  = CLEAR;
                    end else begin
                        for (int i = 0; i < NUM_EFFECTS; i++) begin
                            if (popCmd.idx == 3'(i)) begin
                                effect_d[i] = ~effect_q[i];
                                data_d      = ~effect_q[i];
                            end
                        end
                        addr_d  = ADDR_W'(popCmd.idx);
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (!avm.m_waitrequest) begin
                    write_d = 1'b0;
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (!avm.m_waitrequest) begin
                    if (idx_q == LAST_IDX) begin
                        write_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        addr_d = ADDR_W'(idx_d);
                    end
                end
            end
            default: begin
                write_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            key_q      <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            effect_q   <= '0;
            addr_q     <= '0;
            data_q     <= 1'b0;
            write_q    <= 1'b0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_code_i;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            effect_q   <= effect_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            write_q    <= write_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= newCmd;
        end
    end

    assign avm.m_address   = addr_q;
    assign avm.m_write     = write_q;
    assign avm.m_writedata = {31'b0, data_q};
    assign effect_state_o  = effect_q;
    assign busy_o          = busy_q;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_key_effect_sequencer.sv
// Randomized bench for key_effect_sequencer against a queue-based command model
// plus a scoreboard of expected bus writes.
module tb_key_effect_sequencer;

    localparam int FIFO_DEPTH  = 4;
    localparam int NUM_EFFECTS = 8;
    localparam int ADDR_W      = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [7:0]             keyCode;
    logic                   enable;
    logic [NUM_EFFECTS-1:0] effectState;
    logic                   busy;
    logic                   overflow;

    key_effect_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    key_effect_sequencer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .NUM_EFFECTS(NUM_EFFECTS),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_code_i    (keyCode),
        .enable_i      (enable),
        .avm           (bus.master),
        .effect_state_o(effectState),
        .busy_o        (busy),
        .overflow_o    (overflow)
    );

    always #5 clk = ~clk;

    int totalChecks = 0;
    int badChecks   = 0;

    // Reference model: pending commands (-1 = clear all, else effect index),
    // expected writes encoded as addr*2+data, and beats left on the bus.
    int cmdQueue[$];
    int expWrites[$];
    int beatsLeft;
    int modelEffect;
    bit modelOverflow;
    int prevKey;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        cmdQueue.delete();
        expWrites.delete();
        beatsLeft     = 0;
        modelEffect   = 0;
        modelOverflow = 1'b0;
        prevKey       = 0;
    endtask

    // One clock edge of the command-level behaviour.
    task automatic modelStep(input int key, input bit en, input bit stall, input bit rst);
        int  sizeBefore;
        bit  fresh;
        bit  decoded;
        int  c;
        sizeBefore = cmdQueue.size();
        fresh      = (key != prevKey) && (key != 0);
        prevKey    = key;
        if (rst) begin
            modelReset();
            return;
        end
        if (beatsLeft > 0) begin
            if (!stall) beatsLeft--;
        end else if (cmdQueue.size() > 0) begin
            c = cmdQueue.pop_front();
            if (c < 0) begin
                modelEffect = 0;
                for (int i = 0; i < NUM_EFFECTS; i++) expWrites.push_back(i * 2);
                beatsLeft = NUM_EFFECTS;
            end else begin
                modelEffect = modelEffect ^ (1 << c);
                expWrites.push_back(c * 2 + ((modelEffect >> c) & 1));
                beatsLeft = 1;
            end
        end
        if (fresh && en) begin
            decoded = 1'b1;
            c       = 0;
            if (key == 'h27) c = -1;
            else if (key >= 'h1E && key < 'h1E + NUM_EFFECTS) c = key - 'h1E;
            else decoded = 1'b0;
            if (decoded) begin
                if (sizeBefore == FIFO_DEPTH) modelOverflow = 1'b1;
                else cmdQueue.push_back(c);
            end
        end
    endtask

    // Checks the outputs left by the previous edge, then drives the next edge's inputs.
    task automatic applyStimulus(input logic [7:0] key, input bit en, input bit stall,
                                 input bit rst);
        @(negedge clk);
        checkOutput("m_write", bus.m_write, beatsLeft > 0);
        checkOutput("effect_state", effectState, modelEffect);
        checkOutput("busy", busy, (beatsLeft > 0) || (cmdQueue.size() > 0));
        checkOutput("overflow", overflow, modelOverflow);
        reset             = rst;
        keyCode           = key;
        enable            = en;
        bus.m_waitrequest = stall;
        if (bus.m_write && expWrites.size() > 0) begin
            checkOutput("m_address", bus.m_address, expWrites[0] >> 1);
            checkOutput("m_writedata", bus.m_writedata, expWrites[0] & 1);
            if (!stall && !rst) void'(expWrites.pop_front());
        end
        modelStep(key, en, stall, rst);
    endtask

    logic [7:0] curKey;
    int         holdLeft;
    int         pick;

    initial begin
        reset             = 1'b1;
        keyCode           = 8'h00;
        enable            = 1'b1;
        bus.m_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        modelReset();

        // Single press held, then release.
        repeat (10) applyStimulus(8'h1E, 1, 0, 0);
        repeat (3)  applyStimulus(8'h00, 1, 0, 0);

        // Same key twice toggles back.
        repeat (2) applyStimulus(8'h1F, 1, 0, 0);
        repeat (2) applyStimulus(8'h00, 1, 0, 0);
        repeat (2) applyStimulus(8'h1F, 1, 0, 0);
        repeat (4) applyStimulus(8'h00, 1, 0, 0);

        // Stalled bus with six distinct presses: one in flight, four queued, one dropped.
        for (int k = 0; k < 6; k++) repeat (2) applyStimulus(8'(8'h1E + k), 1, 1, 0);
        repeat (4)  applyStimulus(8'h00, 1, 1, 0);
        repeat (20) applyStimulus(8'h00, 1, 0, 0);

        // Disabled press and an undecoded key.
        repeat (3) applyStimulus(8'h20, 0, 0, 0);
        repeat (3) applyStimulus(8'h99, 1, 0, 0);
        repeat (3) applyStimulus(8'h00, 1, 0, 0);

        // Reset in the middle of a stalled clear-all, then a normal press.
        repeat (2) applyStimulus(8'h22, 1, 0, 0);
        repeat (4) applyStimulus(8'h00, 1, 0, 0);
        repeat (2) applyStimulus(8'h27, 1, 1, 0);
        repeat (3) applyStimulus(8'h00, 1, 1, 0);
        applyStimulus(8'h00, 1, 1, 1);
        repeat (2) applyStimulus(8'h1E, 1, 0, 0);
        repeat (4) applyStimulus(8'h00, 1, 0, 0);

        // Random key traffic with random stalls, disables and rare resets.
        curKey   = 8'h00;
        holdLeft = 0;
        for (int n = 0; n < 1500; n++) begin
            if (holdLeft == 0) begin
                pick = $urandom_range(0, 9);
                if (pick <= 2)      curKey = 8'h00;
                else if (pick <= 7) curKey = 8'(8'h1E + $urandom_range(0, NUM_EFFECTS - 1));
                else if (pick == 8) curKey = 8'h27;
                else                curKey = ($urandom_range(0, 1) == 0) ? 8'h1D : 8'h99;
                holdLeft = $urandom_range(1, 6);
            end
            holdLeft--;
            applyStimulus(curKey, $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 3,
                          $urandom_range(0, 299) == 0);
        end

        // Drain everything still queued.
        repeat (80) applyStimulus(8'h00, 1, 0, 0);
        checkOutput("drain_left", expWrites.size(), 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
